// File: rtl/udma_l2_arb_pkg.sv
// ---------------------------------------------------------------------------
// udma_l2_arb_pkg
// Shared types and constants for the uDMA L2 round-robin arbiter.
//   ARB_*      default configuration of the arbiter (requesters, data width,
//              outstanding-transaction depth)
//   ID_W       width of a requester index for the default configuration
//   l2_req_t   one L2 request payload (wen, addr, wdata, be)
//   ring_add   modular add used for the round-robin scan and pointer update
// ---------------------------------------------------------------------------
package udma_l2_arb_pkg;

    localparam int ARB_N_REQ      = 4;
    localparam int ARB_DATA_WIDTH = 32;
    localparam int ARB_BE_WIDTH   = ARB_DATA_WIDTH / 8;
    localparam int ARB_MAX_OUTST  = 4;
    localparam int ADDR_W         = 32;
    localparam int ID_W           = $clog2(ARB_N_REQ);

    // Payload sized for the default configuration; a top-level DATA_WIDTH
    // override must be mirrored here.
    typedef struct packed {
        logic                    wen;
        logic [ADDR_W-1:0]       addr;
        logic [ARB_DATA_WIDTH-1:0] wdata;
        logic [ARB_BE_WIDTH-1:0] be;
    } l2_req_t;

    // (base + off) mod n, for base < n and off < n.
    function automatic int unsigned ring_add(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        int unsigned s;
        s = base + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/udma_l2_arb_id_fifo.sv
// ---------------------------------------------------------------------------
// udma_l2_arb_id_fifo
// In-order FIFO of requester ids for granted-but-unanswered L2 accesses.
// No fall-through: a pushed id is visible at rdata only from the next cycle.
//   clk, rst_n     clock, async active-low reset (clears pointers/count)
//   push, wdata    enqueue an id (ignored when full)
//   pop            dequeue the head id (ignored when empty)
//   rdata          current head id
//   full, empty    occupancy flags
// ---------------------------------------------------------------------------
module udma_l2_arb_id_fifo
    import udma_l2_arb_pkg::*;
#(
    parameter int DEPTH = ARB_MAX_OUTST,
    parameter int WIDTH = ID_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array has no reset; entries are only read after a
    // push, and the pointers/count already define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/udma_l2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// udma_l2_rr_arbiter
// Round-robin arbiter sharing one TCDM-style L2 port (req/gnt/rvalid) among
// N_REQ requesters; responses are routed back in grant order.
//   sys_clk_i, sys_rst_ni                 clock, async active-low reset
//   req_i, wen_i, addr_i, wdata_i, be_i   per-requester request and payload
//   gnt_o                                 per-requester grant (one-hot/zero)
//   rvalid_o, rdata_o                     per-requester response valid, shared data
//   l2_req_o, l2_wen_o, l2_addr_o,
//   l2_wdata_o, l2_be_o, l2_gnt_i         muxed request to the L2 port
//   l2_rvalid_i, l2_rdata_i               L2 response
//   busy_o                                transactions outstanding
//   err_o                                 sticky: response with nothing outstanding
// ---------------------------------------------------------------------------
module udma_l2_rr_arbiter
    import udma_l2_arb_pkg::*;
#(
    parameter int N_REQ      = ARB_N_REQ,
    parameter int DATA_WIDTH = ARB_DATA_WIDTH,
    parameter int MAX_OUTST  = ARB_MAX_OUTST
) (
    input  logic                    sys_clk_i,
    input  logic                    sys_rst_ni,
    input  logic [N_REQ-1:0]        req_i,
    input  logic [N_REQ-1:0]        wen_i,
    input  logic [ADDR_W-1:0]       addr_i  [N_REQ],
    input  logic [DATA_WIDTH-1:0]   wdata_i [N_REQ],
    input  logic [DATA_WIDTH/8-1:0] be_i    [N_REQ],
    output logic [N_REQ-1:0]        gnt_o,
    output logic [N_REQ-1:0]        rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    l2_req_o,
    input  logic                    l2_gnt_i,
    output logic                    l2_wen_o,
    output logic [ADDR_W-1:0]       l2_addr_o,
    output logic [DATA_WIDTH-1:0]   l2_wdata_o,
    output logic [DATA_WIDTH/8-1:0] l2_be_o,
    input  logic                    l2_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   l2_rdata_i,
    output logic                    busy_o,
    output logic                    err_o
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W-1:0] rr_ptr;
    logic             lock;
    logic [IDX_W-1:0] locked_idx;
    logic             active;      // low in reset and for the first edge after it
    logic             err_q;

    logic [IDX_W-1:0] scan_idx;
    logic [IDX_W-1:0] sel;
    logic             grant;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [IDX_W-1:0] fifo_head;
    l2_req_t          payload;

    // First requester at or after rr_ptr (cyclically). Falls back to rr_ptr
    // when nobody requests; l2_req_o is then low anyway.
    // NOTE: every signal driven in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        logic found;
        found    = 1'b0;
        scan_idx = rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'(ring_add(int'(rr_ptr), k, N_REQ));
            if (!found && req_i[cand]) begin
                scan_idx = cand;
                found    = 1'b1;
            end
        end
    end

    // A stalled request keeps its requester selected until granted, so the
    // L2 port never sees the payload change under an unanswered req.
    assign sel      = lock ? locked_idx : scan_idx;
    assign l2_req_o = active & req_i[sel] & ~fifo_full;
    assign grant    = l2_req_o & l2_gnt_i;

    // Responses are only accepted against a tracked grant; a stray rvalid
    // is flagged instead of popping.
    assign pop    = l2_rvalid_i & ~fifo_empty;
    assign busy_o = ~fifo_empty;
    assign err_o  = err_q;

    always_comb begin
        payload = '0;
        if (l2_req_o) begin
            payload.wen   = wen_i[sel];
            payload.addr  = addr_i[sel];
            payload.wdata = wdata_i[sel];
            payload.be    = be_i[sel];
        end
    end

    assign l2_wen_o   = payload.wen;
    assign l2_addr_o  = payload.addr;
    assign l2_wdata_o = payload.wdata;
    assign l2_be_o    = payload.be;

    always_comb begin
        gnt_o    = '0;
        rvalid_o = '0;
        if (grant) gnt_o[sel]       = 1'b1;
        if (pop)   rvalid_o[fifo_head] = 1'b1;
    end

    assign rdata_o = pop ? l2_rdata_i : '0;

    always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            rr_ptr     <= '0;
            lock       <= 1'b0;
            locked_idx <= '0;
            active     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            active <= 1'b1;
            if (grant) begin
                lock   <= 1'b0;
                rr_ptr <= IDX_W'(ring_add(int'(sel), 1, N_REQ));
            end else if (l2_req_o) begin
                lock       <= 1'b1;
                locked_idx <= sel;
            end else if (lock && !req_i[locked_idx]) begin
                // Requester withdrew a stalled request: release without grant.
                lock <= 1'b0;
            end
            if (l2_rvalid_i && fifo_empty) err_q <= 1'b1;
        end
    end

    udma_l2_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk   (sys_clk_i),
        .rst_n (sys_rst_ni),
        .push  (grant),
        .wdata (sel),
        .pop   (pop),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule
